hv_fault_sequencer: RTL

- Supervisory controller for the high-voltage pulser in the thickness-gauge front end.
- Consumes the debounced fault flags from the protection filters (over-temperature/HV-capacitor fault, sensor-connect status).
- Arbitrates acquisition fire requests against those flags and sequences HV enable through arm, ready, fire, gap, fault-cooldown and lockout.
- Latches a fault code for the host; retries automatically a bounded number of times.

---
 rtl/hv_ctrl_pkg.sv | 37 +++
 rtl/hv_cycle_timer.sv | 45 ++++
 rtl/hv_fault_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hv_ctrl_pkg
// Purpose  : Shared definitions for the HV pulser supervisory controller:
//            state encodings, fault_code bit indices, default timing values
//            and a helper that says which states drive the HV supply.
// Revision : 1.0 - initial release
// ============================================================================
package hv_ctrl_pkg;

  // Sequencer state encodings (3-bit, visible on state_dbg)
  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_FIRE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;
  localparam logic [2:0] ST_LOCK  = 3'd6;

  // fault_code bit positions
  localparam int FC_PROT = 0;
  localparam int FC_SENS = 1;
  localparam int FC_LOCK = 2;

  // Default timing (cycles)
  localparam logic [23:0] ARM_CYC_DEF      = 24'd500000;
  localparam logic [23:0] GAP_CYC_DEF      = 24'd5000;
  localparam logic [23:0] COOLDOWN_CYC_DEF = 24'd10000000;
  localparam logic [3:0]  MAX_RETRY_DEF    = 4'd3;

  // HV supply is on only while charging, waiting, firing or in the gap
  function automatic logic st_hv_on(input logic [2:0] st);
    return (st == ST_ARM) || (st == ST_READY) || (st == ST_FIRE) || (st == ST_GAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hv_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : hv_cycle_timer
// Purpose  : Clear/enable cycle counter with a loadable terminal value.
//            tc_o is high while the count equals term_i; the count then
//            saturates there instead of wrapping.
// Ports    : clk, reset_n   - clock, async active-low reset
//            clr_i          - synchronous clear (priority over en_i)
//            en_i           - count enable
//            term_i[CNT_W]  - terminal value
//            tc_o           - terminal count reached
// Revision : 1.0 - initial release
// ============================================================================
module hv_cycle_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != term_i))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule
`default_nettype wire

// File: rtl/hv_fault_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hv_fault_sequencer
// Purpose  : Supervisory controller for the HV pulser. Sequences HV enable
//            through OFF/ARM/READY/FIRE/GAP, diverts to FAULT on a protect or
//            sensor fault, retries a bounded number of times and then locks
//            out until the host clears it.
// Ports    : clk, reset_n     - clock, async active-low reset
//            protect_en       - 1 = protection fault present
//            sensor_ok_en     - 1 = sensor connected
//            fire_req         - acquisition fire request
//            clear_fault      - host clear pulse
//            hv_enable        - HV supply enable (registered)
//            fire_gnt         - one-cycle fire grant (registered)
//            fault_latched    - sticky fault flag
//            fault_code[2:0]  - {lockout, sensor missing, protect}
//            retry_cnt[3:0]   - automatic retries consumed
//            state_dbg[2:0]   - current state encoding
// Build    : define FIRE_PEND_EN to keep a one-deep pending fire request
//            captured during FIRE/GAP and serviced at GAP expiry.
// Revision : 1.0 - initial release
// ============================================================================
module hv_fault_sequencer
  import hv_ctrl_pkg::*;
#(
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] ARM_CYC      = CNT_W'(ARM_CYC_DEF),
  parameter logic [CNT_W-1:0] GAP_CYC      = CNT_W'(GAP_CYC_DEF),
  parameter logic [CNT_W-1:0] COOLDOWN_CYC = CNT_W'(COOLDOWN_CYC_DEF),
  parameter logic [3:0]       MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       protect_en,
  input  logic       sensor_ok_en,
  input  logic       fire_req,
  input  logic       clear_fault,
  output logic       hv_enable,
  output logic       fire_gnt,
  output logic       fault_latched,
  output logic [2:0] fault_code,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] c_ARM_TERM  = ARM_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_GAP_TERM  = GAP_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_COOL_TERM = COOLDOWN_CYC - CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic             hv_en_q, hv_en_d;
  logic             gnt_q, gnt_d;
  logic             latched_q, latched_d;
  logic [2:0]       code_q, code_d;
  logic [3:0]       retry_q, retry_d;

  logic             w_flt, w_flt_hit, w_tc, w_clr, w_en;
  logic [CNT_W-1:0] w_term;

  assign w_flt     = protect_en | ~sensor_ok_en;
  // Fault is only acted upon while HV is (or is about to be) energised
  assign w_flt_hit = w_flt & st_hv_on(state_q);

  // Shared timer: restarts on every state change, counts in timed states
  assign w_clr = (state_d != state_q);
  assign w_en  = (state_q == ST_ARM) || (state_q == ST_GAP) || (state_q == ST_FAULT);

  always_comb begin
    case (state_q)
      ST_ARM:  w_term = c_ARM_TERM;
      ST_GAP:  w_term = c_GAP_TERM;
      default: w_term = c_COOL_TERM;
    endcase
  end

  hv_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (w_clr),
    .en_i    (w_en),
    .term_i  (w_term),
    .tc_o    (w_tc)
  );

`ifdef FIRE_PEND_EN
  logic pend_q, pend_d, w_pend_hit;

  // A request arriving in the expiry cycle itself is also honoured
  assign w_pend_hit = pend_q | fire_req;

  always_comb begin
    pend_d = pend_q;
    if ((state_d == ST_FAULT) || (state_d == ST_FIRE))
      pend_d = 1'b0;
    else if (((state_q == ST_FIRE) || (state_q == ST_GAP)) && fire_req)
      pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pend_q <= 1'b0;
    else
      pend_q <= pend_d;
  end
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_OFF;
      hv_en_q   <= 1'b0;
      gnt_q     <= 1'b0;
      latched_q <= 1'b0;
      code_q    <= 3'b000;
      retry_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      hv_en_q   <= hv_en_d;
      gnt_q     <= gnt_d;
      latched_q <= latched_d;
      code_q    <= code_d;
      retry_q   <= retry_d;
    end
  end

  // Next-state logic; fault entry outranks every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (!protect_en && sensor_ok_en) state_d = ST_ARM;
      ST_ARM:   if (w_flt) state_d = ST_FAULT;
                else if (w_tc) state_d = ST_READY;
      ST_READY: if (w_flt) state_d = ST_FAULT;
                else if (fire_req) state_d = ST_FIRE;
      ST_FIRE:  if (w_flt) state_d = ST_FAULT;
                else state_d = ST_GAP;
      ST_GAP: begin
        if (w_flt) state_d = ST_FAULT;
        else if (w_tc) begin
`ifdef FIRE_PEND_EN
          state_d = w_pend_hit ? ST_FIRE : ST_READY;
`else
          state_d = ST_READY;
`endif
        end
      end
      ST_FAULT: begin
        if (clear_fault) state_d = ST_OFF;
        else if (w_tc) state_d = (retry_q < MAX_RETRY) ? ST_OFF : ST_LOCK;
      end
      ST_LOCK:  if (clear_fault) state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase
  end

  // Output / status next values, derived from the chosen next state
  always_comb begin
    hv_en_d   = st_hv_on(state_d);
    gnt_d     = (state_d == ST_FIRE);
    latched_d = latched_q;
    code_d    = code_q;
    retry_d   = retry_q;

    if (clear_fault) begin
      latched_d = 1'b0;
      code_d    = 3'b000;
      if ((state_q == ST_FAULT) || (state_q == ST_LOCK))
        retry_d = 4'd0;
    end

    // A new fault in the same cycle as a clear is still recorded
    if (w_flt_hit) begin
      latched_d       = 1'b1;
      code_d[FC_PROT] = code_d[FC_PROT] | protect_en;
      code_d[FC_SENS] = code_d[FC_SENS] | ~sensor_ok_en;
    end

    if ((state_q == ST_FAULT) && !clear_fault && w_tc) begin
      if (retry_q < MAX_RETRY)
        retry_d = retry_q + 4'd1;
      else
        code_d[FC_LOCK] = 1'b1;
    end

    // A delivered grant proves the hardware healthy again
    if (state_q == ST_FIRE)
      retry_d = 4'd0;
  end

  assign hv_enable     = hv_en_q;
  assign fire_gnt      = gnt_q;
  assign fault_latched = latched_q;
  assign fault_code    = code_q;
  assign retry_cnt     = retry_q;
  assign state_dbg     = state_q;

endmodule
`default_nettype wire
